// File: rtl/minirisc_stack_pkg.sv
// Shared types and helpers for the MiniRISC context stack engine.
// Holds the FSM encoding, op codes and the words-per-context ceiling divide.
package minirisc_stack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ctx_stack_engine.sv
// Context save/restore engine: pushes/pops {flags, pc} over the master bus, one word per granted cycle.
// Latency N_WORDS+1 cycles from start to done with grant held high; grant loss stalls with bus_req held.
module ctx_stack_engine
    import minirisc_stack_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                PC_W        = 8,
    parameter int                FLAG_W      = 6,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_pop,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic              busy,
    output logic              done,
    output logic              ovf_err,
    output logic              unf_err,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] depth,
    input  logic              sp_wr,
    input  logic [ADDR_W-1:0] sp_din,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wr,
    output logic              bus_rd,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    localparam int N_WORDS = ceil_div(PC_W + FLAG_W, DATA_W);
    localparam int CTX_W   = N_WORDS * DATA_W;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTX_W-1:0]  ctx_q, ctx_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic [FLAG_W-1:0] flags_out_q, flags_out_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_ok, pop_ok, last_word;
    int                widx;

    // One extra address bit keeps the bounds checks free of wrap-around.
    assign push_ok   = {1'b0, sp_q} >= ({1'b0, STACK_LIMIT} + (ADDR_W+1)'(N_WORDS - 1));
    assign pop_ok    = ({1'b0, sp_q} + (ADDR_W+1)'(N_WORDS)) <= {1'b0, STACK_BASE};
    assign last_word = (cnt_q == CNT_W'(N_WORDS - 1));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        ctx_d       = ctx_q;
        sp_d        = sp_q;
        pc_out_d    = pc_out_q;
        flags_out_d = flags_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_rd      = 1'b0;
        bus_addr    = '0;
        bus_dout    = '0;
        widx        = 0;
        case (state_q)
            ST_IDLE: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (sp_wr) begin
                    sp_d = sp_din;
                end else if (start) begin
                    cnt_d = '0;
                    if (op_pop == OP_POP) begin
                        op_d  = OP_POP;
                        ctx_d = '0;
                        if (pop_ok) state_d = ST_XFER;
                        else begin
                            unf_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        op_d  = OP_PUSH;
                        ctx_d = CTX_W'({flags_in, pc_in});
                        if (push_ok) state_d = ST_XFER;
                        else begin
                            ovf_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_XFER: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    if (op_q == OP_PUSH) begin
                        bus_wr   = 1'b1;
                        bus_addr = sp_q;
                        bus_dout = ctx_q[cnt_q*DATA_W +: DATA_W];
                        sp_d     = sp_q - ADDR_W'(1);
                    end else begin
                        // Pop returns the highest word first, so fill from the top down.
                        widx     = N_WORDS - 1 - int'(cnt_q);
                        bus_rd   = 1'b1;
                        bus_addr = sp_q + ADDR_W'(1);
                        sp_d     = sp_q + ADDR_W'(1);
                        ctx_d[widx*DATA_W +: DATA_W] = bus_din;
                        if (last_word) begin
                            pc_out_d    = ctx_d[PC_W-1:0];
                            flags_out_d = ctx_d[PC_W +: FLAG_W];
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            cnt_q       <= '0;
            ctx_q       <= '0;
            sp_q        <= STACK_BASE;
            pc_out_q    <= '0;
            flags_out_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            ctx_q       <= ctx_d;
            sp_q        <= sp_d;
            pc_out_q    <= pc_out_d;
            flags_out_q <= flags_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign ovf_err   = done & ovf_q;
    assign unf_err   = done & unf_q;
    assign sp        = sp_q;
    assign depth     = STACK_BASE - sp_q;
    assign pc_out    = pc_out_q;
    assign flags_out = flags_out_q;

endmodule
